// File: rtl/alu_cpu_pkg.sv
// Shared opcodes, FSM states and default width for the alu_cpu accumulator core.
package alu_cpu_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_SWAP = 3'b100;
  localparam logic [2:0] OP_CPL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cpu_mul.sv
// Iterative unsigned HALF x HALF shift-add multiplier, MUL_BITS multiplier bits per cycle.
// done/product are combinational during the last step so the caller can write on that edge.
module alu_cpu_mul #(
  parameter int HALF     = 8,
  parameter int MUL_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [HALF-1:0]     a,
  input  logic [HALF-1:0]     b,
  output logic                done,
  output logic [2*HALF-1:0]   product
);

  localparam int STEPS = HALF / MUL_BITS;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [2*HALF-1:0] mcand;
  logic [HALF-1:0]   mplier;
  logic [2*HALF-1:0] partial;
  logic [2*HALF-1:0] step_sum;
  logic [CW-1:0]     cnt;
  logic              busy;

  always_comb begin
    step_sum = '0;
    for (int unsigned i = 0; i < MUL_BITS; i++) begin
      if (mplier[i]) step_sum = step_sum + (mcand << i);
    end
    product = partial + step_sum;
    done    = busy && (cnt == CW'(STEPS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      partial <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      mcand   <= {{HALF{1'b0}}, a};
      mplier  <= b;
      partial <= '0;
      cnt     <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      partial <= product;
      mcand   <= mcand << MUL_BITS;
      mplier  <= mplier >> MUL_BITS;
      cnt     <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_cpu.sv
// Single-accumulator micro-CPU with new_instruction/ready handshake.
// Define ALU_CPU_MUL_EN to build the iterative multiplier; otherwise opcode 110 is a NOP.
module alu_cpu
  import alu_cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MUL_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [2:0]        instruction,
  input  logic              new_instruction,
  output logic [DATA_W-1:0] data_out,
  output logic              ready
);

  localparam int HALF = DATA_W / 2;

  if ((DATA_W % 2) != 0 || (HALF % MUL_BITS) != 0) begin : g_bad_cfg
    $error("alu_cpu: DATA_W must be even and MUL_BITS must divide DATA_W/2");
  end

  state_t            state, state_next;
  logic [2:0]        opcode;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] acc, acc_next;
  logic              acc_we;
  logic              accept;

  assign accept   = (state == IDLE) && new_instruction;
  assign ready    = (state == IDLE);
  assign data_out = acc;

`ifdef ALU_CPU_MUL_EN
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  // Operands are taken straight from acc/data_in on the accept edge, the same
  // values the opcode/operand registers capture on that edge.
  assign mul_start = accept && (instruction == OP_MUL);

  alu_cpu_mul #(
    .HALF     (HALF),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (acc[HALF-1:0]),
    .b       (data_in[DATA_W-1:HALF]),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_comb begin
    state_next = state;
    acc_next   = acc;
    acc_we     = 1'b0;
    case (state)
      IDLE: begin
        if (new_instruction) begin
`ifdef ALU_CPU_MUL_EN
          state_next = (instruction == OP_MUL) ? MUL : EXEC;
`else
          state_next = EXEC;
`endif
        end
      end
      EXEC: begin
        acc_we     = 1'b1;
        state_next = IDLE;
        case (opcode)
          OP_CLR:  acc_next = '0;
          OP_SHR:  acc_next = acc >> 1;
          OP_ADD:  acc_next = acc + operand;
          OP_INC:  acc_next = acc + DATA_W'(1);
          OP_SWAP: acc_next = {acc[HALF-1:0], acc[DATA_W-1:HALF]};
          OP_CPL:  acc_next = ~acc;
          default: acc_next = acc;
        endcase
      end
      MUL: begin
`ifdef ALU_CPU_MUL_EN
        if (mul_done) begin
          acc_we     = 1'b1;
          acc_next   = mul_product;
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      opcode  <= '0;
      operand <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        opcode  <= instruction;
        operand <= data_in;
      end
      if (acc_we) acc <= acc_next;
    end
  end

endmodule

// File: tb/tb_alu_cpu.sv
// Scoreboard bench for alu_cpu: stimulus queues expected results, a negedge monitor checks them.
module tb_alu_cpu;
  import alu_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic [2:0]  instruction = '0;
  logic        new_instruction = 1'b0;
  logic [15:0] data_out;
  logic        ready;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [15:0] exp;
    logic [15:0] hold;
    int unsigned busy;
  } exp_t;

  exp_t        q[$];
  logic [15:0] last = '0;
  int unsigned busy_cnt = 0;
  logic        prev_ready = 1'b1;

`ifdef ALU_CPU_MUL_EN
  localparam logic [15:0] EXP_MUL1 = 16'hCB66;
  localparam logic [15:0] EXP_MUL2 = 16'h0068;
  localparam int unsigned MUL_BUSY = 4;
`else
  localparam logic [15:0] EXP_MUL1 = 16'hFFFE;
  localparam logic [15:0] EXP_MUL2 = 16'h1234;
  localparam int unsigned MUL_BUSY = 1;
`endif

  alu_cpu #(
    .DATA_W   (16),
    .MUL_BITS (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_in         (data_in),
    .instruction     (instruction),
    .new_instruction (new_instruction),
    .data_out        (data_out),
    .ready           (ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt   = 0;
      prev_ready = 1'b1;
    end else begin
      if (!ready) begin
        busy_cnt++;
        if (q.size() > 0) begin
          checks++;
          if (data_out !== q[0].hold) begin
            errors++;
            $display("FAIL hold: data_out=%h required %h", data_out, q[0].hold);
          end
        end
      end else if (!prev_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL completion: data_out=%h but no operation expected", data_out);
        end else begin
          e = q.pop_front();
          if (data_out !== e.exp) begin
            errors++;
            $display("FAIL result: data_out=%h required %h", data_out, e.exp);
          end
          checks++;
          if (busy_cnt != e.busy) begin
            errors++;
            $display("FAIL busy_len: ready low %0d cycles required %0d", busy_cnt, e.busy);
          end
        end
        busy_cnt = 0;
      end
      prev_ready = ready;
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready=%0b required 1", ready);
    end
  endtask

  // Drives a one-cycle request; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [15:0] din,
                       input logic [15:0] exp, input int unsigned busy);
    wait_ready();
    instruction     = op;
    data_in         = din;
    new_instruction = 1'b1;
    q.push_back('{exp, last, busy});
    last = exp;
    @(posedge clk);
    @(negedge clk);
    new_instruction = 1'b0;
    instruction     = OP_CLR;
    data_in         = 16'hA5A5;
  endtask

  initial begin
    #3;
    checks++;
    if (data_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: data_out=%h required 0000", data_out);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready=%0b required 1", ready);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    issue(OP_INC, 16'h0000, 16'h0001, 1);

    // Reset asserted while the op is in flight
    issue(OP_MUL, 16'h0300, 16'h0000, MUL_BUSY);
    #2 rst_n = 1'b0;
    q.delete();
    last = 16'h0000;
    #1;
    checks++;
    if (data_out !== 16'h0000) begin
      errors++;
      $display("FAIL midop_reset_data: data_out=%h required 0000", data_out);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset_ready: ready=%0b required 1", ready);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    issue(OP_CLR, 16'h0000, 16'h0000, 1);
    issue(OP_INC, 16'h0000, 16'h0001, 1);
    issue(OP_CPL, 16'h0000, 16'hFFFE, 1);
    issue(OP_MUL, 16'hCD00, EXP_MUL1, MUL_BUSY);

    issue(OP_CLR,  16'h0000, 16'h0000, 1);
    issue(OP_ADD,  16'hCB66, 16'hCB66, 1);
    issue(OP_SHR,  16'h0000, 16'h65B3, 1);
    issue(OP_SWAP, 16'h0000, 16'hB365, 1);
    issue(OP_ADD,  16'hCD0F, 16'h8074, 1);

    // CLR pulsed while busy must be ignored
    issue(OP_INC, 16'h0000, 16'h8075, 1);
    new_instruction = 1'b1;
    instruction     = OP_CLR;
    @(negedge clk);
    new_instruction = 1'b0;

    // Held request re-issues at each ready edge
    issue(OP_CLR, 16'h0000, 16'h0000, 1);
    wait_ready();
    instruction     = OP_INC;
    new_instruction = 1'b1;
    q.push_back('{16'h0001, last, 1});
    q.push_back('{16'h0002, 16'h0001, 1});
    last = 16'h0002;
    repeat (3) @(posedge clk);
    @(negedge clk);
    new_instruction = 1'b0;

    issue(OP_CLR, 16'h0000, 16'h0000, 1);
    issue(OP_CPL, 16'h0000, 16'hFFFF, 1);
    issue(OP_INC, 16'h0000, 16'h0000, 1);

    issue(OP_ADD, 16'h1234, 16'h1234, 1);
    issue(OP_MUL, 16'h0200, EXP_MUL2, MUL_BUSY);
    issue(OP_NOP, 16'hFFFF, EXP_MUL2, 1);

    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results pending required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
